// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - load-use/branch stall, mem-wait freeze and watchdog control for the 5-stage pipeline
// Optional HAZARD_PERF_EN adds stall_cycles/freeze_cycles performance counters.
module hazard_stall_unit #(
  parameter int REG_W    = 5,
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] ID_RegRs,
  input  logic [REG_W-1:0] ID_RegRt,
  input  logic             ID_UsesRt,
  input  logic             ID_Branch,
  input  logic             Branch_Taken,
  input  logic             EX_RegWrite,
  input  logic             EX_MemRead,
  input  logic [REG_W-1:0] EX_RegRd,
  input  logic             MEM_MemRead,
  input  logic             MEM_MemWrite,
  input  logic [REG_W-1:0] MEM_RegRd,
  input  logic             dmem_ready,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IDEX_Bubble,
  output logic             IFID_Flush,
  output logic             PipeFreeze,
  output logic             mem_timeout
`ifdef HAZARD_PERF_EN
  ,
  output logic [15:0]      stall_cycles,
  output logic [15:0]      freeze_cycles
`endif
);

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LP_MAX    = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] LP_MAX_M1 = CNT_W'(MAX_WAIT - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_timeout;

  logic w_rt_used;
  logic w_rs_ex, w_rt_ex, w_rs_mem, w_rt_mem;
  logic w_ex_hit, w_mem_hit;
  logic w_load_use, w_br_hazard, w_stall, w_flush;
  logic w_mem_busy;
  logic w_cnt_inc;

  // Register 0 is hardwired to zero, so it never creates a dependency.
  assign w_rt_used = ID_UsesRt | ID_Branch;
  assign w_rs_ex   = (EX_RegRd  != '0) && (EX_RegRd  == ID_RegRs);
  assign w_rt_ex   = w_rt_used && (EX_RegRd  != '0) && (EX_RegRd  == ID_RegRt);
  assign w_rs_mem  = (MEM_RegRd != '0) && (MEM_RegRd == ID_RegRs);
  assign w_rt_mem  = w_rt_used && (MEM_RegRd != '0) && (MEM_RegRd == ID_RegRt);
  assign w_ex_hit  = w_rs_ex  | w_rt_ex;
  assign w_mem_hit = w_rs_mem | w_rt_mem;

  assign w_load_use  = EX_MemRead & w_ex_hit;
  assign w_br_hazard = ID_Branch & ((EX_RegWrite & w_ex_hit) | (MEM_MemRead & w_mem_hit));
  assign w_stall     = w_load_use | w_br_hazard;
  assign w_flush     = ID_Branch & Branch_Taken;
  assign w_mem_busy  = (MEM_MemRead | MEM_MemWrite) & ~dmem_ready;

  assign w_cnt_inc = (r_state == ST_MEM_WAIT) && !dmem_ready && (r_wait_cnt < LP_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_next_state == ST_RUN) begin
        r_wait_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      if (w_cnt_inc && (r_wait_cnt == LP_MAX_M1)) begin
        r_timeout <= 1'b1;
      end
    end
  end

  // Freeze is taken straight from mem_busy so the first wait cycle needs no state delay.
  always_comb begin
    w_next_state = r_state;
    PCWrite      = 1'b1;
    IFIDWrite    = 1'b1;
    IDEX_Bubble  = 1'b0;
    IFID_Flush   = 1'b0;
    PipeFreeze   = 1'b0;
    mem_timeout  = 1'b0;

    case (r_state)
      ST_RUN:      if (w_mem_busy) w_next_state = ST_MEM_WAIT;
      ST_MEM_WAIT: if (dmem_ready) w_next_state = ST_RUN;
      default:     w_next_state = ST_RUN;
    endcase

    if (!reset) begin
      mem_timeout = r_timeout;
      if (w_mem_busy) begin
        PCWrite    = 1'b0;
        IFIDWrite  = 1'b0;
        PipeFreeze = 1'b1;
      end else if (w_stall) begin
        PCWrite     = 1'b0;
        IFIDWrite   = 1'b0;
        IDEX_Bubble = 1'b1;
      end else if (w_flush) begin
        IFID_Flush = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  logic [15:0] r_stall_cycles;
  logic [15:0] r_freeze_cycles;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cycles  <= '0;
      r_freeze_cycles <= '0;
    end else begin
      if (IDEX_Bubble) r_stall_cycles  <= r_stall_cycles + 16'd1;
      if (PipeFreeze)  r_freeze_cycles <= r_freeze_cycles + 16'd1;
    end
  end

  assign stall_cycles  = r_stall_cycles;
  assign freeze_cycles = r_freeze_cycles;
`endif

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Producer-side hazard controller for the 5-stage MIPS pipeline; the complement of the EX-stage forwarding logic.
- Covers the hazards forwarding cannot resolve:
  - load-use,
  - branch operands needed in ID,
  - data-memory wait states.
- Drives PC/IF-ID write enables, the ID/EX bubble, the IF/ID flush and a global pipeline freeze.
- Tracks memory-wait duration with a watchdog counter.

Parameters:
- REG_W, 5, register-specifier width.
- MAX_WAIT, 15, MEM_WAIT cycles before mem_timeout sets (1..255).
- CNT_W, 8, width of wait counter (must hold MAX_WAIT).

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- ID_RegRs  input  REG_W  rs of instruction in ID.
- ID_RegRt  input  REG_W  rt of instruction in ID.
- ID_UsesRt  input  1  ID instruction reads rt (R-type, beq/bne, sw).
- ID_Branch  input  1  ID instruction is beq/bne (compared in ID).
- Branch_Taken  input  1  ID comparator result, valid when ID_Branch.
- EX_RegWrite  input  1  EX instruction writes a register.
- EX_MemRead  input  1  EX instruction is a load.
- EX_RegRd  input  REG_W  EX destination (after RegDst mux).
- MEM_MemRead  input  1  MEM-stage load.
- MEM_MemWrite  input  1  MEM-stage store.
- MEM_RegRd  input  REG_W  MEM destination.
- dmem_ready  input  1  data memory completes access this cycle.
- PCWrite  output  1  PC update enable.
- IFIDWrite  output  1  IF/ID register enable.
- IDEX_Bubble  output  1  zero ID/EX control fields.
- IFID_Flush  output  1  clear IF/ID instruction (squash fetched slot).
- PipeFreeze  output  1  hold EX/MEM and MEM/WB; bubble into WB.
- mem_timeout  output  1  sticky watchdog flag.

Behaviour:
- Match rule: match(X,r) = (X != 0) && (X == r).
  - Rs-match uses ID_RegRs.
  - Rt-match uses ID_RegRt, and counts only when ID_UsesRt or ID_Branch.
- load_use = EX_MemRead && (match(EX_RegRd,rs) || match(EX_RegRd,rt)).
- br_hazard = ID_Branch && any of:
  - EX_RegWrite && match(EX_RegRd, rs or rt);
  - MEM_MemRead && match(MEM_RegRd, rs or rt).
  - Effect: ALU→branch costs 1 stall; load→branch costs 2 stalls.
- mem_busy = (MEM_MemRead || MEM_MemWrite) && !dmem_ready.
- FSM states:
  - RUN: mem_busy → MEM_WAIT.
  - MEM_WAIT: dmem_ready → RUN; otherwise stay.
- freeze = mem_busy (combinational, both states; the first wait cycle is frozen without a state delay).
- Outputs (combinational), priority freeze > stall > flush:
  - freeze: PCWrite=0, IFIDWrite=0, IDEX_Bubble=0, IFID_Flush=0, PipeFreeze=1.
  - stall (load_use || br_hazard): PCWrite=0, IFIDWrite=0, IDEX_Bubble=1, IFID_Flush=0, PipeFreeze=0.
  - flush (ID_Branch && Branch_Taken, no stall): PCWrite=1, IFIDWrite=1, IFID_Flush=1.
  - otherwise: PCWrite=1, IFIDWrite=1, rest 0.
- A taken branch held by a hazard does not flush until the hazard clears (its operands are not valid yet).
- wait_cnt:
  - Cleared on entry to RUN.
  - Increments each clock in MEM_WAIT while !dmem_ready; saturates at MAX_WAIT.
  - mem_timeout sets on the clock where wait_cnt == MAX_WAIT-1 and the increment occurs.
  - mem_timeout is cleared only by reset.
- Reset: state=RUN, wait_cnt=0, mem_timeout=0.
  - While reset is high, outputs are forced to PCWrite=1, IFIDWrite=1, others 0, regardless of inputs.
  - Reset during MEM_WAIT aborts the wait in the same cycle.
- Register 0 never causes a hazard.
- dmem_ready asserted with no MEM access is ignored.

Optional Feature:
- HAZARD_PERF_EN defined: adds outputs
  - stall_cycles [15:0], counting cycles with stall asserted;
  - freeze_cycles [15:0], counting cycles with freeze asserted.
  - Both wrap at 16'hFFFF→0 and clear on reset.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Load-use:
  - Stimulus: EX_MemRead=1, EX_RegRd=8; ID_RegRs=8.
  - Response: PCWrite=0, IFIDWrite=0, IDEX_Bubble=1 for exactly that cycle.
  - Repeat with EX_RegRd=0: no stall.
- Load→branch:
  - Cycle 1: ID_Branch=1, rt=9, EX_MemRead=1, EX_RegRd=9 → stall.
  - Cycle 2: same ID, MEM_MemRead=1, MEM_RegRd=9, EX bubble → stall.
  - Cycle 3: Branch_Taken=1 → IFID_Flush=1.
  - Total 2 stalls, then 1 flush.
- Memory wait:
  - Stimulus: MEM_MemWrite=1, dmem_ready=0 for 3 cycles, then 1.
  - Response: PipeFreeze=1 and PCWrite=0 for 3 cycles; RUN on the 4th; wait_cnt back to 0; mem_timeout=0.
- Watchdog:
  - Stimulus: MAX_WAIT=4, MEM_MemRead=1, dmem_ready=0 for 6 cycles.
  - Response: mem_timeout=1 after the 4th wait clock and stays set after dmem_ready=1 until reset.
- Priority:
  - Stimulus: mem_busy, load_use and a taken branch all in one cycle.
  - Response: freeze only (IDEX_Bubble=0, IFID_Flush=0).
  - Then assert reset mid-MEM_WAIT: next cycle state=RUN, PipeFreeze follows inputs, mem_timeout=0.
- HAZARD_PERF_EN:
  - Stimulus: 3 stall cycles and 2 freeze cycles.
  - Response: stall_cycles=3, freeze_cycles=2; both 0 after reset.
